i2c_slave_regbank: RTL and testbench

I2C_SLAVE_REGBANK -- requirements
Module: i2c_slave_regbank

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_bus_monitor.sv | 59 +++++
 rtl/i2c_slave_regbank.sv | 262 ++++++++++++++++++++++++++
 tb/tb_i2c_slave_regbank.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the slave register bank (and by a future
// master): FSM state encoding, ACK/NACK bus levels and bit-counter width.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    REG_PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    STRETCH,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_e;

  // Level seen on SDA during the 9th clock of a byte.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Counts 0..8 bits of a byte; 8 means "byte complete, waiting for SCL fall".
  localparam int BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(7);
  localparam logic [BIT_CNT_W-1:0] BYTE_DONE = BIT_CNT_W'(8);

endpackage

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: brings SCL/SDA into the clk domain and detects bus events.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   scl_in, sda_in      raw bus levels (asynchronous)
//   sda                 synchronised SDA level
//   scl_rise, scl_fall  one-cycle strobes on synchronised SCL edges
//   start_det, stop_det one-cycle strobes for START / STOP conditions
module i2c_bus_monitor (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl;

  assign scl = scl_sync_q[1];
  assign sda = sda_sync_q[1];

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_prev_d = scl;
    sda_prev_d = sda;
  end

  // Idle bus is high on both lines, so everything resets to 1 to avoid
  // spurious edges right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_rise  =  scl & ~scl_prev_q;
  assign scl_fall  = ~scl &  scl_prev_q;
  // SCL must be high on both samples so an SDA change racing an SCL edge
  // is not mistaken for START/STOP.
  assign start_det = scl & scl_prev_q &  sda_prev_q & ~sda;
  assign stop_det  = scl & scl_prev_q & ~sda_prev_q &  sda;

endmodule

// File: rtl/i2c_slave_regbank.sv
// I2C slave exposing REG_DEPTH 8-bit registers.
// Write: START, addr+W, register pointer, data bytes..., STOP.
// Read : START, addr+R, data bytes from current pointer..., STOP.
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   scl_in, sda_in        bus levels (asynchronous)
//   scl_oe, sda_oe        1 = pull line low (open drain)
//   stretch_en            hold SCL low STRETCH_CYCLES after each write-data ACK
//   host_addr/host_rdata  combinational side-band read (out of range -> 0)
//   wr_pulse/addr/data    one-cycle notification of each I2C register write
//   busy                  transaction in progress (START .. STOP)
module i2c_slave_regbank
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR     = 7'h42,
  parameter int         REG_DEPTH      = 16,
  parameter int         STRETCH_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       stretch_en,
  input  logic [7:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       wr_pulse,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int PTR_W = (REG_DEPTH > 2) ? $clog2(REG_DEPTH) : 1;
  localparam int STR_W = (STRETCH_CYCLES > 2) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(REG_DEPTH - 1);
  localparam logic [STR_W-1:0] STR_LAST = STR_W'(STRETCH_CYCLES - 1);
  localparam logic [8:0]       DEPTH9   = 9'(REG_DEPTH);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_monitor u_mon (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]           rx_q, rx_d;     // bits received so far
  logic [6:0]           tx_q, tx_d;     // read bits not yet on the bus
  logic                 rw_q, rw_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 scl_oe_q, scl_oe_d;
  logic [STR_W-1:0]     str_cnt_q, str_cnt_d;
  logic                 wr_pulse_q, wr_pulse_d;
  logic [7:0]           wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic [7:0]           regs_q [REG_DEPTH];
  logic [7:0]           regs_d [REG_DEPTH];

  logic [7:0] rx_byte;
  logic [7:0] rd_byte;

  assign rx_byte = {rx_q, sda};
  assign rd_byte = regs_q[ptr_q];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Reads the flops directly, so a same-cycle I2C write shows the old value.
  always_comb begin
    host_rdata = 8'h00;
    if ({1'b0, host_addr} < DEPTH9) host_rdata = regs_q[host_addr[PTR_W-1:0]];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    rw_d       = rw_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    scl_oe_d   = scl_oe_q;
    str_cnt_d  = str_cnt_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    regs_d     = regs_q;

    if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
    end else if (start_det) begin
      // Also covers repeated START; pointer is left untouched.
      state_d  = DEV_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        DEV_ADDR, REG_PTR, WR_DATA: begin
          if (scl_rise && cnt_q != BYTE_DONE) begin
            rx_d  = rx_byte[6:0];
            cnt_d = cnt_q + BIT_CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              if (state_q == DEV_ADDR) begin
                if (rx_byte[7:1] != SLAVE_ADDR) state_d = WAIT_STOP;
                else                            rw_d    = rx_byte[0];
              end else if (state_q == REG_PTR) begin
                if ({1'b0, rx_byte} < DEPTH9) ptr_d   = rx_byte[PTR_W-1:0];
                else                          state_d = WAIT_STOP;
              end else begin
                regs_d[ptr_q] = rx_byte;
                wr_pulse_d    = 1'b1;
                wr_addr_d     = 8'(ptr_q);
                wr_data_d     = rx_byte;
                ptr_d         = ptr_inc(ptr_q);
              end
            end
          end else if (scl_fall && cnt_q == BYTE_DONE) begin
            // Byte accepted: pull SDA to the ACK level for the 9th clock.
            sda_oe_d = ~ACK;
            cnt_d    = '0;
            if (state_q == DEV_ADDR)     state_d = DEV_ACK;
            else if (state_q == REG_PTR) state_d = PTR_ACK;
            else                         state_d = WR_ACK;
          end
        end

        DEV_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              state_d  = RD_DATA;
              tx_d     = rd_byte[6:0];
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = REG_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end

        PTR_ACK: begin
          if (scl_fall) begin
            state_d  = WR_DATA;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            if (stretch_en) begin
              state_d   = STRETCH;
              scl_oe_d  = 1'b1;
              str_cnt_d = '0;
            end else begin
              state_d = WR_DATA;
            end
          end
        end

        // scl_oe is high on every cycle spent here, counted 0..STRETCH_CYCLES-1.
        STRETCH: begin
          if (str_cnt_q == STR_LAST) begin
            scl_oe_d = 1'b0;
            state_d  = WR_DATA;
          end else begin
            str_cnt_d = str_cnt_q + STR_W'(1);
          end
        end

        // Bit 7 is already on SDA on entry; each rise is one bit consumed.
        RD_DATA: begin
          if (scl_rise && cnt_q != BYTE_DONE) begin
            cnt_d = cnt_q + BIT_CNT_W'(1);
          end else if (scl_fall) begin
            if (cnt_q == BYTE_DONE) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
              cnt_d    = '0;
              ptr_d    = ptr_inc(ptr_q);
            end else begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
            end
          end
        end

        // cnt_q==1 marks "master ACKed, send next byte on the coming fall".
        RD_ACK: begin
          if (scl_rise) begin
            if (sda == NACK) state_d = WAIT_STOP;
            else             cnt_d   = BIT_CNT_W'(1);
          end else if (scl_fall && cnt_q == BIT_CNT_W'(1)) begin
            state_d  = RD_DATA;
            cnt_d    = '0;
            tx_d     = rd_byte[6:0];
            sda_oe_d = ~rd_byte[7];
          end
        end

        default: ;  // IDLE, WAIT_STOP: only START/STOP matter
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      str_cnt_q  <= '0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      scl_oe_q   <= scl_oe_d;
      str_cnt_q  <= str_cnt_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      regs_q     <= regs_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign scl_oe   = scl_oe_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Bench for i2c_slave_regbank: a bit-level I2C master drives the bus, a
// transaction-level register model predicts ACKs, read data and write
// strobes, and a monitor process compares DUT responses against them.
module tb_i2c_slave_regbank;
  import i2c_pkg::*;

  localparam int         DEPTH = 16;
  localparam int         HP    = 8;     // SCL half period in clk cycles
  localparam logic [6:0] SADDR = 7'h42;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       m_scl_low = 1'b0, m_sda_low = 1'b0;
  logic       scl_bus, sda_bus;
  logic       scl_oe, sda_oe, stretch_en = 1'b0;
  logic [7:0] host_addr = 8'h00, host_rdata;
  logic       wr_pulse, busy;
  logic [7:0] wr_addr, wr_data;

  assign scl_bus = ~(m_scl_low | scl_oe);
  assign sda_bus = ~(m_sda_low | sda_oe);

  i2c_slave_regbank #(.SLAVE_ADDR(SADDR), .REG_DEPTH(DEPTH), .STRETCH_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_bus), .sda_in(sda_bus),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .stretch_en(stretch_en),
    .host_addr(host_addr), .host_rdata(host_rdata),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  int n_checks = 0, n_fail = 0;
  bit finished = 0;

  typedef struct { int kind; logic [7:0] val; } rsp_t;  // kind 0 = ack bit, 1 = read byte
  rsp_t        exp_rsp[$], act_rsp[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  tx_bytes[$];
  logic [7:0]  model_regs [256];
  int          model_ptr = 0;
  logic        sampled;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_test();
    if (!finished) begin
      finished = 1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    end
    $finish;
  endtask

  initial begin
    #900000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached, test incomplete");
    finish_test();
  end

  // Scoreboard monitor: write strobes and bus responses vs. predictions.
  initial forever begin
    @(negedge clk);
    if (wr_pulse) begin
      if (exp_wr.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr_pulse: unexpected strobe addr=%0h data=%0h, none required", wr_addr, wr_data);
      end else begin
        logic [15:0] e;
        e = exp_wr.pop_front();
        check("wr_addr", wr_addr, e[15:8]);
        check("wr_data", wr_data, e[7:0]);
      end
    end
    while (act_rsp.size() > 0) begin
      rsp_t a, e;
      a = act_rsp.pop_front();
      if (exp_rsp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL response: got %0h with no prediction", a.val);
      end else begin
        e = exp_rsp.pop_front();
        check(e.kind == 0 ? "ack" : "rdata", a.val, e.val);
      end
    end
  end

  // Length of each SCL stretch seen from the DUT.
  int run_len = 0, last_run = 0, n_runs = 0;
  always @(posedge clk) begin
    if (scl_oe) run_len <= run_len + 1;
    else if (run_len != 0) begin
      last_run <= run_len;
      n_runs   <= n_runs + 1;
      run_len  <= 0;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_release();
    int t = 0;
    m_scl_low = 1'b0;
    while (scl_bus !== 1'b1) begin
      @(negedge clk);
      t++;
      if (t > 300) begin
        n_checks++; n_fail++;
        $display("FAIL scl_release: SCL held low %0d cycles, required release", t);
        finish_test();
      end
    end
  endtask

  task automatic bit_xfer(input logic b);
    m_sda_low = ~b;
    wait_n(HP);
    scl_release();
    wait_n(HP / 2);
    sampled = sda_bus;
    wait_n(HP / 2);
    m_scl_low = 1'b1;
    wait_n(HP);
  endtask

  task automatic start_cond();
    m_sda_low = 1'b0;
    wait_n(HP);
    scl_release();
    wait_n(HP);
    m_sda_low = 1'b1;
    wait_n(HP);
    m_scl_low = 1'b1;
    wait_n(HP);
  endtask

  task automatic stop_cond();
    m_sda_low = 1'b1;
    wait_n(HP);
    scl_release();
    wait_n(HP);
    m_sda_low = 1'b0;
    wait_n(HP);
  endtask

  task automatic push_exp(input int kind, input logic [7:0] v);
    rsp_t r; r.kind = kind; r.val = v; exp_rsp.push_back(r);
  endtask

  task automatic push_act(input int kind, input logic [7:0] v);
    rsp_t r; r.kind = kind; r.val = v; act_rsp.push_back(r);
  endtask

  // Send a byte; the ACK level the master sees goes to the scoreboard.
  task automatic send_byte(input logic [7:0] d, input logic exp_ack);
    push_exp(0, {7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) bit_xfer(d[i]);
    bit_xfer(1'b1);
    push_act(0, {7'd0, sampled});
  endtask

  task automatic recv_byte(input logic [7:0] exp_d, input logic mack);
    logic [7:0] d;
    push_exp(1, exp_d);
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1);
      d[i] = sampled;
    end
    bit_xfer(mack);
    push_act(1, d);
  endtask

  task automatic stop_end();
    stop_cond();
    wait_n(4);
    check("busy_after_stop", busy, 0);
    check("sda_released", sda_oe, 0);
    check("scl_released", scl_oe, 0);
  endtask

  // Write transaction: address, pointer, then tx_bytes.
  task automatic wr_txn(input logic [6:0] a7, input int ptr);
    start_cond();
    check("busy_after_start", busy, 1);
    send_byte({a7, 1'b0}, (a7 == SADDR) ? ACK : NACK);
    if (a7 != SADDR) begin stop_end(); return; end
    send_byte(8'(ptr), (ptr < DEPTH) ? ACK : NACK);
    if (ptr >= DEPTH) begin stop_end(); return; end
    model_ptr = ptr;
    foreach (tx_bytes[i]) begin
      exp_wr.push_back({8'(model_ptr), tx_bytes[i]});
      model_regs[model_ptr] = tx_bytes[i];
      model_ptr = (model_ptr + 1) % DEPTH;
      send_byte(tx_bytes[i], ACK);
    end
    stop_end();
  endtask

  // Read n bytes; set_ptr >= 0 first loads the pointer then repeated START.
  task automatic rd_txn(input int set_ptr, input int n);
    start_cond();
    if (set_ptr >= 0) begin
      send_byte({SADDR, 1'b0}, ACK);
      send_byte(8'(set_ptr), (set_ptr < DEPTH) ? ACK : NACK);
      if (set_ptr < DEPTH) model_ptr = set_ptr;
      start_cond();
    end
    send_byte({SADDR, 1'b1}, ACK);
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      e = model_regs[model_ptr];
      model_ptr = (model_ptr + 1) % DEPTH;
      recv_byte(e, (i == n - 1) ? NACK : ACK);
    end
    check("sda_after_master_nack", sda_oe, 0);
    stop_end();
  endtask

  task automatic sweep();
    for (int a = 0; a < DEPTH + 2; a++) begin
      host_addr = 8'(a);
      #1;
      check("host_rdata", host_rdata, (a < DEPTH) ? model_regs[a] : 8'h00);
    end
    host_addr = 8'hFF;
    #1;
    check("host_rdata_oob", host_rdata, 8'h00);
  endtask

  initial begin
    int runs0;
    for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;

    wait_n(3);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    wait_n(5);

    tx_bytes = '{8'h5A};             wr_txn(SADDR, 2);
    tx_bytes = '{8'h11, 8'h22, 8'h33}; wr_txn(SADDR, 15);
    sweep();
    rd_txn(2, 2);
    tx_bytes = '{8'h77};
    wr_txn(7'h43, 1);
    wr_txn(SADDR, 8'h20);

    stretch_en = 1'b1;
    runs0 = n_runs;
    tx_bytes = '{8'hCC};
    wr_txn(SADDR, 3);
    check("stretch_count", n_runs - runs0, 1);
    check("stretch_len", last_run, 64);
    stretch_en = 1'b0;
    sweep();

    for (int k = 0; k < 12; k++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        int len;
        len = $urandom_range(1, 4);
        tx_bytes = {};
        for (int j = 0; j < len; j++) tx_bytes.push_back(8'($urandom_range(0, 255)));
        wr_txn(SADDR, $urandom_range(0, DEPTH - 1));
      end else if (kind == 1) begin
        rd_txn($urandom_range(0, DEPTH - 1), $urandom_range(1, 3));
      end else if (kind == 2) begin
        rd_txn(-1, $urandom_range(1, 2));
      end else begin
        logic [6:0] a7;
        a7 = 7'($urandom_range(0, 127));
        if (a7 == SADDR) a7 = 7'h11;
        tx_bytes = '{8'($urandom_range(0, 255))};
        if ($urandom_range(0, 1) == 0) wr_txn(a7, 1);
        else                           wr_txn(SADDR, $urandom_range(DEPTH, 255));
      end
    end
    sweep();

    // Reset in the middle of a read while the DUT is pulling SDA low.
    tx_bytes = '{8'h05};
    wr_txn(SADDR, 4);
    start_cond();
    send_byte({SADDR, 1'b0}, ACK);
    send_byte(8'd4, ACK);
    start_cond();
    send_byte({SADDR, 1'b1}, ACK);
    bit_xfer(1'b1);
    bit_xfer(1'b1);
    check("rd_bit5_driven", sda_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_sda_oe", sda_oe, 0);
    check("rst_mid_scl_oe", scl_oe, 0);
    check("rst_mid_busy", busy, 0);
    wait_n(2);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    sweep();
    stop_cond();
    wait_n(HP);
    tx_bytes = '{8'hA7};
    wr_txn(SADDR, 9);
    rd_txn(9, 1);
    sweep();

    wait_n(10);
    check("pending_writes", exp_wr.size(), 0);
    check("pending_responses", exp_rsp.size(), 0);
    finish_test();
  end

endmodule
